wb_csr_commit: RTL and testbench

- WB-stage commit controller that drives the CPU's CSR file from the pipeline side.
- Turns committing CSR instructions into CSR read/write requests: csrrd, csrwr, csrxchg, rdcnt*.
- Resolves exceptions and interrupts: generates wb_ex, ecode, esubcode, ertn_flush and the pipeline flush/redirect.
- Owns the 64-bit stable counter and the post-flush drain state machine.

---
 rtl/wb_csr_commit.sv | 224 ++++++++++++++++++++++
 tb/tb_wb_csr_commit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_csr_commit.sv
`default_nettype none
// ============================================================================
// Module      : wb_csr_commit
// Description : WB-stage commit controller. Turns committing CSR-class
//               instructions into CSR file requests, resolves exceptions and
//               interrupts, raises the pipeline flush/redirect and holds the
//               pipeline in a drain state until fetch accepts the redirect.
//               Also owns the 64-bit stable counter read by rdcntv{l,h}.w.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_csr_commit #(
    parameter logic [13:0] CSR_TID_NUM = 14'h040,
    parameter int          CNT_W       = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [2:0]  wb_op,
    input  logic [13:0] wb_csr_num,
    input  logic [31:0] wb_rj_value,
    input  logic [31:0] wb_rd_value,
    input  logic [4:0]  wb_exc,
    input  logic [31:0] wb_vaddr_in,
    input  logic [31:0] csr_rvalue,
    input  logic [31:0] csr_eentry_data,
    input  logic [31:0] csr_era_pc,
    input  logic        has_int,
    input  logic        redirect_ack,
    output logic        csr_re,
    output logic [13:0] csr_num,
    output logic        csr_we,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    output logic        wb_ex,
    output logic        ertn_flush,
    output logic [31:0] wb_ex_pc,
    output logic [31:0] wb_vaddr,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic        flush,
    output logic [31:0] flush_target,
    output logic        rf_we,
    output logic [31:0] rf_wdata,
    output logic        drain
);

    // Instruction encodings on wb_op
    localparam logic [2:0] OP_NONE    = 3'd0;
    localparam logic [2:0] OP_CSRRD   = 3'd1;
    localparam logic [2:0] OP_CSRWR   = 3'd2;
    localparam logic [2:0] OP_CSRXCHG = 3'd3;
    localparam logic [2:0] OP_ERTN    = 3'd4;
    localparam logic [2:0] OP_RDCNTVL = 3'd5;
    localparam logic [2:0] OP_RDCNTVH = 3'd6;
    localparam logic [2:0] OP_RDCNTID = 3'd7;

    // Exception codes
    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    // Commit FSM states
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    // wb_exc bit positions: {ale, brk, sys, ine, adef}
    localparam int EXC_ADEF = 0;
    localparam int EXC_INE  = 1;
    localparam int EXC_SYS  = 2;
    localparam int EXC_BRK  = 3;

    logic [0:0]       state_q, state_d;
    logic             int_pend_q, int_pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             w_commit;
    logic             w_exc_any;

    // Reset forces every output low, so reset is folded into commit.
    assign w_commit  = wb_valid & (state_q == ST_RUN) & ~reset;
    assign w_exc_any = int_pend_q | (|wb_exc);
    assign drain     = (state_q == ST_DRAIN) & ~reset;

    // Exception resolution and CSR/GPR request generation for the commit cycle
    always_comb begin
        csr_re      = 1'b0;
        csr_num     = 14'd0;
        csr_we      = 1'b0;
        csr_wmask   = 32'd0;
        csr_wvalue  = 32'd0;
        wb_ex       = 1'b0;
        ertn_flush  = 1'b0;
        wb_ex_pc    = 32'd0;
        wb_vaddr    = 32'd0;
        wb_ecode    = 6'd0;
        wb_esubcode = 9'd0;
        rf_we       = 1'b0;
        rf_wdata    = 32'd0;

        if (w_commit && w_exc_any) begin
            // Exception commit suppresses every architectural side effect.
            wb_ex    = 1'b1;
            wb_ex_pc = wb_pc;
            wb_vaddr = wb_pc;
            if (int_pend_q) begin
                wb_ecode = ECODE_INT;
            end else if (wb_exc[EXC_ADEF]) begin
                wb_ecode = ECODE_ADE;
            end else if (wb_exc[EXC_INE]) begin
                wb_ecode = ECODE_INE;
            end else if (wb_exc[EXC_SYS]) begin
                wb_ecode = ECODE_SYS;
            end else if (wb_exc[EXC_BRK]) begin
                wb_ecode = ECODE_BRK;
            end else begin
                // Only ALE remains; it reports the faulting data address.
                wb_ecode = ECODE_ALE;
                wb_vaddr = wb_vaddr_in;
            end
        end else if (w_commit) begin
            case (wb_op)
                OP_CSRRD: begin
                    csr_re   = 1'b1;
                    csr_num  = wb_csr_num;
                    rf_we    = 1'b1;
                    rf_wdata = csr_rvalue;
                end
                OP_CSRWR: begin
                    csr_re     = 1'b1;
                    csr_num    = wb_csr_num;
                    csr_we     = 1'b1;
                    csr_wmask  = 32'hFFFF_FFFF;
                    csr_wvalue = wb_rd_value;
                    rf_we      = 1'b1;
                    rf_wdata   = csr_rvalue;
                end
                OP_CSRXCHG: begin
                    csr_re     = 1'b1;
                    csr_num    = wb_csr_num;
                    csr_we     = 1'b1;
                    csr_wmask  = wb_rj_value;
                    csr_wvalue = wb_rd_value;
                    rf_we      = 1'b1;
                    rf_wdata   = csr_rvalue;
                end
                OP_ERTN: begin
                    ertn_flush = 1'b1;
                end
                OP_RDCNTVL: begin
                    rf_we    = 1'b1;
                    rf_wdata = cnt_q[31:0];
                end
                OP_RDCNTVH: begin
                    rf_we    = 1'b1;
                    rf_wdata = cnt_q[63:32];
                end
                OP_RDCNTID: begin
                    csr_re   = 1'b1;
                    csr_num  = CSR_TID_NUM;
                    rf_we    = 1'b1;
                    rf_wdata = csr_rvalue;
                end
                OP_NONE: begin
                    rf_we = 1'b0;
                end
                default: begin
                    rf_we = 1'b0;
                end
            endcase
        end
    end

    // Flush and redirect target; exception beats ertn beats CSR write
    always_comb begin
        flush        = 1'b0;
        flush_target = 32'd0;
        if (wb_ex) begin
            flush        = 1'b1;
            flush_target = csr_eentry_data;
        end else if (ertn_flush) begin
            flush        = 1'b1;
            flush_target = csr_era_pc;
        end else if (csr_we) begin
            flush        = 1'b1;
            flush_target = wb_pc + 32'd4;
        end
    end

    // Next state: interrupt tag is sticky until an instruction commits,
    // FSM drains after any flush, counter free-runs
    always_comb begin
        int_pend_d = has_int | (int_pend_q & ~w_commit);
        cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        state_d    = state_q;
        if (state_q == ST_RUN) begin
            if (flush) begin
                state_d = ST_DRAIN;
            end
        end else begin
            if (redirect_ack) begin
                state_d = ST_RUN;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            int_pend_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            int_pend_q <= int_pend_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_csr_commit.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_csr_commit
// Description : Directed self-checking bench for wb_csr_commit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_csr_commit;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [2:0]  wb_op;
    logic [13:0] wb_csr_num;
    logic [31:0] wb_rj_value;
    logic [31:0] wb_rd_value;
    logic [4:0]  wb_exc;
    logic [31:0] wb_vaddr_in;
    logic [31:0] csr_rvalue;
    logic [31:0] csr_eentry_data;
    logic [31:0] csr_era_pc;
    logic        has_int;
    logic        redirect_ack;
    logic        csr_re;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic        ertn_flush;
    logic [31:0] wb_ex_pc;
    logic [31:0] wb_vaddr;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic        flush;
    logic [31:0] flush_target;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic        drain;

    int n_total = 0;
    int n_bad   = 0;

    wb_csr_commit dut (
        .clk             (clk),
        .reset           (reset),
        .wb_valid        (wb_valid),
        .wb_pc           (wb_pc),
        .wb_op           (wb_op),
        .wb_csr_num      (wb_csr_num),
        .wb_rj_value     (wb_rj_value),
        .wb_rd_value     (wb_rd_value),
        .wb_exc          (wb_exc),
        .wb_vaddr_in     (wb_vaddr_in),
        .csr_rvalue      (csr_rvalue),
        .csr_eentry_data (csr_eentry_data),
        .csr_era_pc      (csr_era_pc),
        .has_int         (has_int),
        .redirect_ack    (redirect_ack),
        .csr_re          (csr_re),
        .csr_num         (csr_num),
        .csr_we          (csr_we),
        .csr_wmask       (csr_wmask),
        .csr_wvalue      (csr_wvalue),
        .wb_ex           (wb_ex),
        .ertn_flush      (ertn_flush),
        .wb_ex_pc        (wb_ex_pc),
        .wb_vaddr        (wb_vaddr),
        .wb_ecode        (wb_ecode),
        .wb_esubcode     (wb_esubcode),
        .flush           (flush),
        .flush_target    (flush_target),
        .rf_we           (rf_we),
        .rf_wdata        (rf_wdata),
        .drain           (drain)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Acknowledge the redirect, then confirm the block is back in RUN.
    task automatic leave_drain();
        @(negedge clk);
        wb_valid     = 1'b0;
        wb_exc       = 5'd0;
        redirect_ack = 1'b1;
        @(negedge clk);
        redirect_ack = 1'b0;
        #1;
        chk("drain_exit", 64'(drain), 64'd0);
    endtask

    // Exception vectors: {wb_exc, expected ecode, expect ALE vaddr}
    logic [4:0] exc_vec   [5] = '{5'b10100, 5'b10000, 5'b00011, 5'b01010, 5'b11000};
    logic [5:0] ecode_vec [5] = '{6'h0B,    6'h09,    6'h08,    6'h0D,    6'h0C};
    logic       ale_vec   [5] = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        wb_valid        = 1'b1;
        wb_pc           = 32'h1C00_0000;
        wb_op           = 3'd2;
        wb_csr_num      = 14'h030;
        wb_rj_value     = 32'd0;
        wb_rd_value     = 32'h1234;
        wb_exc          = 5'd0;
        wb_vaddr_in     = 32'h1234_5678;
        csr_rvalue      = 32'hAA;
        csr_eentry_data = 32'h1C00_8000;
        csr_era_pc      = 32'h1C00_0100;
        has_int         = 1'b0;
        redirect_ack    = 1'b0;

        // Reset cycle: a csrwr presented during reset produces nothing
        @(negedge clk);
        #1;
        chk("rst_csr_we", 64'(csr_we), 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_drain", 64'(drain), 64'd0);

        // Release reset, counter runs for 10 edges
        @(negedge clk);
        reset    = 1'b0;
        wb_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        wb_valid = 1'b1;
        wb_op    = 3'd5;
        #1;
        chk("cntvl_10", 64'(rf_wdata), 64'd10);
        chk("cntvl_rf_we", 64'(rf_we), 64'd1);
        chk("cntvl_no_csr", 64'(csr_re), 64'd0);
        chk("cntvl_no_flush", 64'(flush), 64'd0);

        // csrwr
        @(negedge clk);
        wb_op       = 3'd2;
        wb_pc       = 32'h1C00_0010;
        wb_csr_num  = 14'h030;
        wb_rd_value = 32'h1234;
        csr_rvalue  = 32'hAA;
        #1;
        chk("wr_re", 64'(csr_re), 64'd1);
        chk("wr_num", 64'(csr_num), 64'h30);
        chk("wr_we", 64'(csr_we), 64'd1);
        chk("wr_mask", 64'(csr_wmask), 64'hFFFF_FFFF);
        chk("wr_value", 64'(csr_wvalue), 64'h1234);
        chk("wr_rf_wdata", 64'(rf_wdata), 64'hAA);
        chk("wr_rf_we", 64'(rf_we), 64'd1);
        chk("wr_ex", 64'(wb_ex), 64'd0);
        chk("wr_flush", 64'(flush), 64'd1);
        chk("wr_target", 64'(flush_target), 64'h1C00_0014);
        chk("wr_drain_pre", 64'(drain), 64'd0);

        // DRAIN: wb_valid held, nothing issued until ack
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("drn_drain", 64'(drain), 64'd1);
            chk("drn_flush", 64'(flush), 64'd0);
            chk("drn_we", 64'(csr_we), 64'd0);
            chk("drn_rf_we", 64'(rf_we), 64'd0);
        end
        leave_drain();

        // csrxchg with redirect_ack in the flush cycle (ack ignored)
        @(negedge clk);
        wb_valid     = 1'b1;
        wb_op        = 3'd3;
        wb_rj_value  = 32'h0000_FF00;
        wb_rd_value  = 32'hDEAD_BEEF;
        redirect_ack = 1'b1;
        #1;
        chk("xchg_we", 64'(csr_we), 64'd1);
        chk("xchg_mask", 64'(csr_wmask), 64'h0000_FF00);
        chk("xchg_value", 64'(csr_wvalue), 64'hDEAD_BEEF);
        chk("xchg_flush", 64'(flush), 64'd1);
        @(negedge clk);
        redirect_ack = 1'b0;
        #1;
        chk("xchg_ack_ignored", 64'(drain), 64'd1);
        leave_drain();

        // Exception priority table, csrwr underneath must be suppressed
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wb_valid = 1'b1;
            wb_op    = 3'd2;
            wb_pc    = 32'h1C00_0020 + 32'(i * 4);
            wb_exc   = exc_vec[i];
            #1;
            chk("exc_ex", 64'(wb_ex), 64'd1);
            chk("exc_ecode", 64'(wb_ecode), 64'(ecode_vec[i]));
            chk("exc_esub", 64'(wb_esubcode), 64'd0);
            chk("exc_we", 64'(csr_we), 64'd0);
            chk("exc_rf_we", 64'(rf_we), 64'd0);
            chk("exc_target", 64'(flush_target), 64'h1C00_8000);
            chk("exc_pc", 64'(wb_ex_pc), 64'(32'h1C00_0020 + 32'(i * 4)));
            chk("exc_vaddr", 64'(wb_vaddr),
                ale_vec[i] ? 64'h1234_5678 : 64'(32'h1C00_0020 + 32'(i * 4)));
            leave_drain();
        end

        // Interrupt for one cycle, then a csrwr takes the interrupt
        @(negedge clk);
        wb_valid = 1'b0;
        has_int  = 1'b1;
        @(negedge clk);
        has_int  = 1'b0;
        wb_valid = 1'b1;
        wb_op    = 3'd2;
        wb_pc    = 32'h1C00_0040;
        #1;
        chk("int_ex", 64'(wb_ex), 64'd1);
        chk("int_ecode", 64'(wb_ecode), 64'h00);
        chk("int_we", 64'(csr_we), 64'd0);
        chk("int_target", 64'(flush_target), 64'h1C00_8000);
        leave_drain();
        @(negedge clk);
        wb_valid   = 1'b1;
        wb_op      = 3'd1;
        wb_csr_num = 14'h005;
        csr_rvalue = 32'h5555_0001;
        #1;
        chk("int_cleared", 64'(wb_ex), 64'd0);
        chk("rd_re", 64'(csr_re), 64'd1);
        chk("rd_num", 64'(csr_num), 64'h005);
        chk("rd_wdata", 64'(rf_wdata), 64'h5555_0001);
        chk("rd_no_we", 64'(csr_we), 64'd0);
        chk("rd_mask0", 64'(csr_wmask), 64'd0);
        chk("rd_no_flush", 64'(flush), 64'd0);

        // rdcntid.w uses the fixed TID number
        @(negedge clk);
        wb_op      = 3'd7;
        wb_csr_num = 14'h055;
        csr_rvalue = 32'h0000_0077;
        #1;
        chk("tid_num", 64'(csr_num), 64'h040);
        chk("tid_re", 64'(csr_re), 64'd1);
        chk("tid_wdata", 64'(rf_wdata), 64'h77);

        // ertn, then wb_valid during DRAIN is ignored
        @(negedge clk);
        wb_op = 3'd4;
        #1;
        chk("ertn_flush", 64'(ertn_flush), 64'd1);
        chk("ertn_fl", 64'(flush), 64'd1);
        chk("ertn_target", 64'(flush_target), 64'h1C00_0100);
        chk("ertn_rf_we", 64'(rf_we), 64'd0);
        @(negedge clk);
        wb_op = 3'd2;
        #1;
        chk("ertn_drn_we", 64'(csr_we), 64'd0);
        chk("ertn_drn_rfwe", 64'(rf_we), 64'd0);
        chk("ertn_drn_eflush", 64'(ertn_flush), 64'd0);
        chk("ertn_drn_flush", 64'(flush), 64'd0);
        chk("ertn_drn_drain", 64'(drain), 64'd1);

        // Reset during DRAIN returns to RUN with no flush
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_drn_drain", 64'(drain), 64'd0);
        chk("rst_drn_flush", 64'(flush), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        wb_op = 3'd1;
        #1;
        chk("post_rst_re", 64'(csr_re), 64'd1);
        chk("post_rst_drain", 64'(drain), 64'd0);

        // Counter upper-half carry
        @(negedge clk);
        wb_valid = 1'b0;
        force dut.cnt_q = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.cnt_q;
        @(negedge clk);
        wb_valid = 1'b1;
        wb_op    = 3'd6;
        #1;
        chk("cntvh_carry", 64'(rf_wdata), 64'd1);

        // Counter wrap at 2^64-1
        @(negedge clk);
        force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("cntvh_max", 64'(rf_wdata), 64'hFFFF_FFFF);
        release dut.cnt_q;
        @(negedge clk);
        wb_op = 3'd5;
        #1;
        chk("cnt_wrap", 64'(rf_wdata), 64'd0);

        @(negedge clk);
        wb_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
